// File: rtl/cdb_arbiter.sv
// Purpose : shares the common data bus between ALU and load results; each source has a private FIFO, round-robin drain.
// Latency : 2 cycles from push accept to cdb_valid (FIFO write, then registered CDB); no input-to-CDB bypass.
// Backpress: x_ready drops while the FIFO is full (registered count only); the CDB itself is never stalled.
//
// Ports (cdb_fifo):
//   clk_in, rst_in     clock, asynchronous active-low reset
//   en                 global enable; freezes all state when low, forces ready low
//   clear              synchronous flush (qualified by en); drops same-cycle pushes
//   push_vld/push_dat  producer side, transfer on push_vld & ready
//   pop                drain head entry (caller only pops a non-empty FIFO)
//   ready, not_empty   status from the registered count
//   head_dat           entry at the read pointer
module cdb_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         en,
  input  logic         clear,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         ready,
  output logic         not_empty,
  output logic [W-1:0] head_dat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Ready looks only at the registered count, so a pop in the same cycle
  // never frees a slot for the producer until the next cycle.
  assign ready     = en & (count < CW'(DEPTH));
  assign not_empty = (count != '0);
  assign head_dat  = mem[rptr];

  assign do_push = push_vld & ready & ~clear;
  assign do_pop  = en & ~clear & pop & not_empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (en) begin
      if (clear) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (do_push) wptr <= wptr + PW'(1);
        if (do_pop)  rptr <= rptr + PW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wptr] <= push_dat;
  end
endmodule

// Purpose : CDB writeback arbiter between ALU and LoadStoreBuffer results, flushed on rob_clear.
// Latency : 2 cycles push-to-broadcast; one broadcast per cycle, strict ALU/LSB alternation when both busy.
// Backpress: alu_ready/lsb_ready from per-source FIFO occupancy; cdb_valid is a one-cycle pulse, never stalled.
//
// Ports:
//   clk_in, rst_in, rdy_in, rob_clear        clock, async active-low reset, global enable, flush
//   alu_valid/alu_rob_idx/alu_value/alu_ready ALU result handshake
//   lsb_valid/lsb_rob_idx/lsb_value/lsb_ready load result handshake
//   cdb_valid/cdb_rob_idx/cdb_value/cdb_src   registered broadcast (src 0 = ALU, 1 = LSB)
module cdb_arbiter #(
  parameter int ROB_IDX_W = 4,
  parameter int DEPTH     = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 rob_clear,
  input  logic                 alu_valid,
  input  logic [ROB_IDX_W-1:0] alu_rob_idx,
  input  logic [31:0]          alu_value,
  output logic                 alu_ready,
  input  logic                 lsb_valid,
  input  logic [ROB_IDX_W-1:0] lsb_rob_idx,
  input  logic [31:0]          lsb_value,
  output logic                 lsb_ready,
  output logic                 cdb_valid,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [31:0]          cdb_value,
  output logic                 cdb_src
);
  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [31:0]          value;
  } entry_t;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  entry_t alu_in, lsb_in, alu_head, lsb_head;
  logic   alu_ne, lsb_ne;
  logic   grant_alu, grant_lsb;
  logic   last_grant;

  assign alu_in = '{rob_idx: alu_rob_idx, value: alu_value};
  assign lsb_in = '{rob_idx: lsb_rob_idx, value: lsb_value};

  cdb_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_alu_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (rdy_in),
    .clear     (rob_clear),
    .push_vld  (alu_valid),
    .push_dat  (alu_in),
    .pop       (grant_alu),
    .ready     (alu_ready),
    .not_empty (alu_ne),
    .head_dat  (alu_head)
  );

  cdb_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_lsb_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (rdy_in),
    .clear     (rob_clear),
    .push_vld  (lsb_valid),
    .push_dat  (lsb_in),
    .pop       (grant_lsb),
    .ready     (lsb_ready),
    .not_empty (lsb_ne),
    .head_dat  (lsb_head)
  );

  // LSB wins when it is the only candidate, or on a tie when ALU went last.
  // Grants are masked while frozen or flushing so nothing pops.
  always_comb begin
    grant_lsb = 1'b0;
    grant_alu = 1'b0;
    if (rdy_in && !rob_clear) begin
      grant_lsb = lsb_ne & (~alu_ne | (last_grant == SRC_ALU));
      grant_alu = alu_ne & ~grant_lsb;
    end
  end

  // last_grant only advances on a tie; a lone source does not steal the turn.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_value   <= '0;
      cdb_src     <= SRC_ALU;
      last_grant  <= SRC_LSB;
    end else if (rdy_in) begin
      if (rob_clear) begin
        cdb_valid  <= 1'b0;
        last_grant <= SRC_LSB;
      end else if (grant_alu || grant_lsb) begin
        cdb_valid   <= 1'b1;
        cdb_rob_idx <= grant_lsb ? lsb_head.rob_idx : alu_head.rob_idx;
        cdb_value   <= grant_lsb ? lsb_head.value : alu_head.value;
        cdb_src     <= grant_lsb;
        if (alu_ne && lsb_ne) last_grant <= grant_lsb;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) writeback path between the ALU and the LoadStoreBuffer load-result port.
- Each producer pushes results into a private FIFO through a valid/ready handshake.
- The arbiter drains one result per cycle onto a registered CDB, using round-robin when both FIFOs hold data.
- The CDB feeds the ReorderBuffer, ReservationStation and LoadStoreBuffer wakeup inputs; the whole block is flushed on rob_clear.

Parameters:
- ROB_IDX_W, 4, width of ROB index fields.
- DEPTH, 2, entries per source FIFO; must be a power of two, 2 or more.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; when low, all state is frozen.
- rob_clear  input  1  misprediction flush; synchronous.
- alu_valid  input  1  ALU result present this cycle.
- alu_rob_idx  input  ROB_IDX_W  ROB index of the ALU result.
- alu_value  input  32  ALU result value.
- alu_ready  output  1  ALU FIFO can accept.
- lsb_valid  input  1  load result present this cycle.
- lsb_rob_idx  input  ROB_IDX_W  ROB index of the load result.
- lsb_value  input  32  load result value.
- lsb_ready  output  1  LSB FIFO can accept.
- cdb_valid  output  1  CDB broadcast valid (registered).
- cdb_rob_idx  output  ROB_IDX_W  broadcast ROB index (registered).
- cdb_value  output  32  broadcast value (registered).
- cdb_src  output  1  source of the broadcast: 0 = ALU, 1 = LSB (registered).

Behaviour:
- Reset (rst_in = 0, asynchronous):
  - FIFOs empty, counts 0.
  - cdb_valid = 0, cdb_rob_idx = 0, cdb_value = 0, cdb_src = 0.
  - last_grant = LSB, so the ALU wins the first tie.
  - alu_ready and lsb_ready are 1 once out of reset.
- Ready:
  - x_ready = rdy_in AND count_x < DEPTH.
  - Computed from the registered count only; a same-cycle pop gives no credit.
- Push:
  - A transfer happens on an edge where x_valid AND x_ready.
  - The entry is written at the wptr slot; wptr wraps modulo DEPTH.
  - x_valid while x_ready = 0 is ignored (the producer must hold it); the entry is not written.
- Arbitration (evaluated each edge with rdy_in = 1 and rob_clear = 0, on the pre-edge FIFO contents):
  - Only ALU FIFO non-empty: grant ALU.
  - Only LSB FIFO non-empty: grant LSB.
  - Both non-empty: grant the source not equal to last_grant, then update last_grant.
  - Neither non-empty: cdb_valid <= 0; the other CDB fields hold.
  - On a grant: the head entry is copied to the CDB registers, cdb_valid <= 1, cdb_src = winner, and that FIFO pops (rptr wraps).
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance. A full FIFO that pops still reports ready = 0 that cycle.
- Latency: accepted at edge k, earliest cdb_valid is in the cycle after edge k+1 (2 cycles). There is no input-to-CDB bypass.
- Throughput: 1 result per cycle total. With both sources saturated, grants alternate strictly ALU/LSB.
- cdb_valid is a one-cycle pulse per result; there is no backpressure from CDB consumers.
- rob_clear = 1 with rdy_in = 1:
  - Both FIFOs emptied (pointers and counts to 0); pushes that cycle are dropped.
  - cdb_valid <= 0; last_grant <= LSB.
  - alu_ready and lsb_ready stay combinationally valid that cycle, but accepted data is discarded.
- rdy_in = 0:
  - No push, pop or flush; CDB registers and last_grant hold.
  - Ready outputs are 0; rob_clear is ignored.
- Count width is clog2(DEPTH)+1. FIFO order is preserved per source; there is no ordering guarantee across sources.

Test Plan:
- Reset, then alu_valid for one cycle with idx 3 and value 0x12345678 -> cdb_valid for exactly one cycle, 2 cycles later, with idx 3, value 0x12345678, src 0.
- ALU and LSB both push every cycle for 6 cycles (ALU idx 0..5, LSB idx 8..13) -> CDB order ALU0, LSB8, ALU1, LSB9, ...; ALU is first after reset.
- LSB pushes 3 entries back-to-back with DEPTH = 2 and the ALU FIFO also non-empty -> lsb_ready drops to 0 after 2 accepts; the held third entry is accepted only after an LSB pop; no loss or duplication.
- Fill both FIFOs, then assert rob_clear for 1 cycle together with a new alu_valid -> cdb_valid = 0 next cycle, the dropped entry never appears, and no stale entry is broadcast afterwards.
- rdy_in low for 3 cycles with both FIFOs non-empty and cdb_valid = 1 -> CDB outputs hold, ready outputs are 0, and the count is unchanged. After rdy_in rises, draining resumes with the same round-robin turn.
- Pulse rst_in low mid-stream without a clock edge -> outputs go to 0 immediately and all entries are lost.
